shift_reg_lr_rotate: RTL and testbench



---
 rtl/shift_reg_lr_rotate.sv | 69 ++++++
 tb/tb_shift_reg_lr_rotate.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_reg_lr_rotate.sv
// shift_reg_lr_rotate
// N-bit bidirectional rotate register with synchronous parallel load and a
// rotate enable. Load has priority over rotation; with neither, the register
// holds. The register contents drive the mem output directly.
//
// Optional feature: define SHIFT_REG_LR_ROTATE_ZERO_FLAG_EN to add a
// registered "zero" output. It is high whenever mem is all zeros, and it
// resets to 1. Without the macro, the port and its logic are absent.

module shift_reg_lr_rotate #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en,
    input  logic         right,
    input  logic         load,
    input  logic [N-1:0] data_i,
    output logic [N-1:0] mem
`ifdef SHIFT_REG_LR_ROTATE_ZERO_FLAG_EN
    ,
    output logic         zero
`endif
);

    // A rotate needs at least two bits to be meaningful.
    if (N < 2) begin : g_bad_width
        $error("shift_reg_lr_rotate: N must be at least 2");
    end

    logic [N-1:0] mem_nxt;

    // Next-state selection: load beats rotate, and rotate beats hold.
    always_comb begin
        // NOTE: default assignment first so every path assigns mem_nxt; no latch is inferred.
        mem_nxt = mem;
        if (load) begin
            mem_nxt = data_i;
        end else if (en) begin
            if (right) begin
                mem_nxt = {mem[0], mem[N-1:1]};
            end else begin
                mem_nxt = {mem[N-2:0], mem[N-1]};
            end
        end
    end

    // State register. Asynchronous clear, then commit the selected next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem <= '0;
        end else begin
            // NOTE: non-blocking assignment keeps every flop sampling pre-edge values.
            mem <= mem_nxt;
        end
    end

`ifdef SHIFT_REG_LR_ROTATE_ZERO_FLAG_EN
    // Zero flag. It is computed from the next state, so it lines up with mem.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            zero <= 1'b1;
        end else begin
            zero <= (mem_nxt == '0);
        end
    end
`endif

endmodule

// File: tb/tb_shift_reg_lr_rotate.sv
// Testbench for shift_reg_lr_rotate.
// The stimulus process computes the expected register contents from the
// rotate rules and queues them. A monitor process pops each expectation
// one step after the clock edge and compares it with the DUT.

module tb_shift_reg_lr_rotate;

    localparam int N = 8;

    logic         clk;
    logic         reset_n;
    logic         en;
    logic         right;
    logic         load;
    logic [N-1:0] data_i;
    logic [N-1:0] mem;
`ifdef SHIFT_REG_LR_ROTATE_ZERO_FLAG_EN
    logic         zero;
`endif

    typedef struct packed {
        logic [N-1:0] mem;
        logic         zero;
    } exp_t;

    exp_t         exp_q[$];
    logic [N-1:0] model;
    int           checks;
    int           failures;

    shift_reg_lr_rotate #(.N(N)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .right   (right),
        .load    (load),
        .data_i  (data_i),
        .mem     (mem)
`ifdef SHIFT_REG_LR_ROTATE_ZERO_FLAG_EN
        ,
        .zero    (zero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference rotations, written as shifts on the whole word.
    function automatic logic [N-1:0] rot_right(input logic [N-1:0] m);
        return (m >> 1) | (m << (N - 1));
    endfunction

    function automatic logic [N-1:0] rot_left(input logic [N-1:0] m);
        return (m << 1) | (m >> (N - 1));
    endfunction

    task automatic push_expected();
        exp_t e;
        e.mem  = model;
        e.zero = (model == '0);
        exp_q.push_back(e);
    endtask

    // Drive one cycle of controls on the falling edge and queue the result.
    task automatic step(input logic l, input logic e, input logic r, input logic [N-1:0] d);
        @(negedge clk);
        load   = l;
        en     = e;
        right  = r;
        data_i = d;
        if (l)
            model = d;
        else if (e)
            model = r ? rot_right(model) : rot_left(model);
        push_expected();
    endtask

    // Release reset with en = load = 0. The register must read zero after the edge.
    task automatic release_reset();
        @(negedge clk);
        load    = 1'b0;
        en      = 1'b0;
        right   = 1'b0;
        data_i  = N'($urandom);
        reset_n = 1'b1;
        model   = '0;
        push_expected();
    endtask

    // Pull reset low between edges. The clear must be visible before the next edge.
    task automatic async_reset(input string name);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check(name, 32'(mem), 32'h0);
`ifdef SHIFT_REG_LR_ROTATE_ZERO_FLAG_EN
        check({name, "_zero"}, 32'(zero), 32'h1);
`endif
        model = '0;
        repeat (2) @(posedge clk);
        #1;
        check({name, "_held"}, 32'(mem), 32'h0);
        release_reset();
    endtask

    // Monitor: one expectation per committed edge, sampled just after the edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (reset_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("mem", 32'(mem), 32'(e.mem));
`ifdef SHIFT_REG_LR_ROTATE_ZERO_FLAG_EN
            check("zero", 32'(zero), 32'(e.zero));
`endif
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        model    = '0;
        reset_n  = 1'b0;
        en       = 1'b0;
        right    = 1'b0;
        load     = 1'b0;
        data_i   = '0;

        // Reset is asynchronous, so mem is already clear before the first edge.
        #1;
        check("reset_async", 32'(mem), 32'h0);
`ifdef SHIFT_REG_LR_ROTATE_ZERO_FLAG_EN
        check("reset_zero", 32'(zero), 32'h1);
`endif
        repeat (2) @(posedge clk);
        release_reset();

        // Load with en set, then hold for two cycles.
        step(1'b1, 1'b1, 1'b0, 8'hAC);
        step(1'b0, 1'b0, 1'b1, 8'h5A);
        step(1'b0, 1'b0, 1'b0, 8'hFF);

        // Rotate right 3 times, then rotate left 4 times.
        repeat (3) step(1'b0, 1'b1, 1'b1, N'($urandom));
        repeat (4) step(1'b0, 1'b1, 1'b0, N'($urandom));
        @(posedge clk);
        #2;
        check("seq_end_0x59", 32'(mem), 32'h59);

        // Load takes priority over rotate.
        step(1'b1, 1'b1, 1'b1, 8'h61);
        // Enable gap, then rotate right.
        step(1'b0, 1'b0, 1'b1, N'($urandom));
        step(1'b0, 1'b1, 1'b1, N'($urandom));
        @(posedge clk);
        #2;
        check("gap_0xB0", 32'(mem), 32'hB0);

        // Reset in the middle of a rotation.
        step(1'b0, 1'b1, 1'b0, N'($urandom));
        async_reset("reset_mid_rotate");

        // Full wrap: 0x01 rotated left N times returns to 0x01.
        step(1'b1, 1'b0, 1'b0, 8'h01);
        repeat (N - 1) step(1'b0, 1'b1, 1'b0, N'($urandom));
        @(posedge clk);
        #2;
        check("wrap_msb", 32'(mem), 32'h80);
        step(1'b0, 1'b1, 1'b0, N'($urandom));
        @(posedge clk);
        #2;
        check("wrap_full", 32'(mem), 32'h01);

        // Randomized traffic, with loads of zero mixed in.
        for (int i = 0; i < 300; i++) begin
            logic         l;
            logic         e;
            logic         r;
            logic [N-1:0] d;
            l = ($urandom_range(0, 5) == 0);
            e = ($urandom_range(0, 3) != 0);
            r = 1'($urandom);
            d = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
            step(l, e, r, d);
            if (i == 150)
                async_reset("reset_random");
        end

        // Drain the queue, with a bounded wait.
        repeat (3) @(posedge clk);
        #2;
        check("drain", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
